mult_mat_seq: RTL
=================

Name: mult_mat_seq

Overview:
- Parametrised, sequential successor to the fixed 2x2 matrix multiplier.
- Computes R = A x B for square NxN matrices of unsigned W-bit elements, one multiply-accumulate per enabled cycle.
- Provides a start/done handshake, a global clock enable, and selectable wrap or saturate result reduction with a sticky overflow flag.
- Sits between the matrix operand registers and the result consumer in the matrix datapath.

Parameters:
- N, 2, matrix dimension (N >= 2).
- W, 3, element width in bits (W >= 2).
- SAT, 0, reduction mode: 0 keeps the low W bits (wrap); 1 clamps to 2^W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk_enable  in  1  global enable; when 0, all state holds.
- start  in  1  request a multiply; sampled only in IDLE with clk_enable=1.
- matriz_A  in  N*N*W  operand A; element (i,j) at bits [(i*N+j)*W +: W].
- matriz_B  in  N*N*W  operand B; same packing.
- matriz_resultado  out  N*N*W  result R; same packing.
- busy  out  1  high while in CALC or FIN.
- done  out  1  high for exactly one enabled cycle, in FIN.
- overflow  out  1  sticky: some element of the last operation exceeded 2^W-1.

Behaviour:
- Reset (async assert, sync release): state=IDLE; matriz_resultado=0, busy=0, done=0, overflow=0; counters and accumulator cleared.
- Reset mid-operation aborts the operation. No partial result appears on the outputs.
- All updates occur only on rising edges with clk_enable=1. With clk_enable=0, everything holds, including done.
- FSM states:
  - IDLE: when start=1, capture A and B into internal registers, clear i/j/k, clear acc, clear overflow, go to CALC.
  - CALC: each edge adds a(i,k)*b(k,j) to acc.
    - k increments 0..N-1. When k=N-1, the reduced value of (acc+product) goes to res_buf(i,j), acc clears, k wraps to 0, and j increments.
    - j wraps to 0 and increments i, giving row-major order.
    - After the (N-1,N-1,N-1) edge, go to FIN and copy res_buf to matriz_resultado atomically on that same edge.
  - FIN: done=1 for one enabled cycle, then IDLE.
- Latency: done is high in the cycle that follows the N^3-th enabled edge after the start edge (N=2: 8 enabled edges).
- matriz_resultado changes only on the FIN-entry edge. It holds the previous result throughout CALC.
- Operands are captured at start. Changes to matriz_A/matriz_B while busy have no effect.
- start is ignored while busy, including in FIN. A start in the cycle after FIN is accepted.
- Arithmetic:
  - Product width is 2W.
  - Accumulator width is 2W+clog2(N); the accumulator cannot overflow.
  - An element sum > 2^W-1 sets overflow, in both modes.
  - SAT=0 stores sum[W-1:0]. SAT=1 stores min(sum, 2^W-1).
- overflow is cleared only by reset or an accepted start.

Decomposition:
- Package mult_mat_pkg holds:
  - the state enum (IDLE, CALC, FIN);
  - a function for accumulator width, 2W+clog2(N);
  - element-index helper functions for packing/unpacking.
- One sub-module, mult_mat_reduce: combinational, with inputs acc+product and SAT, outputs the W-bit element and an ovf bit.
- FSM, counters and buffers stay in mult_mat_seq.

Test Plan:
- Basic (N=2, W=3, SAT=0): A=12'h2D1 ([[1,2],[3,1]]), B=12'h242 ([[2,0],[1,1]]), pulse start -> done after 8 edges; matriz_resultado=12'h3D4 ([[4,2],[7,1]]); overflow=0; busy high for 9 cycles.
- Wrap vs saturate: A=B=12'hFFF (all 7s, sums 98) -> SAT=0 gives 12'h492, overflow=1; SAT=1 gives 12'hFFF, overflow=1. A following start with the basic operands clears overflow to 0.
- Stall: drop clk_enable for 5 cycles at CALC step 3 -> done delayed by exactly 5 cycles; result still 12'h3D4; done stays high while clk_enable=0 in FIN.
- Busy protection: start pulsed, and matriz_A changed to 12'h000, during CALC -> ignored; result 12'h3D4. The previous matriz_resultado is held until the FIN edge.
- Reset mid-operation: assert rst_n=0 at CALC step 4 -> outputs 0 immediately (asynchronous). After release, a new start yields the correct result with no residue from the aborted operation.
- Scaling (N=3, W=4, SAT=0): A=identity, B=elements 1..9 row-major -> result equals B after 27 edges. A=B=all 15 -> each sum 675, giving 675 mod 16 = 3 in every element; overflow=1.

Source files
------------

// File: rtl/mult_mat_pkg.sv
// Shared types and index helpers for the sequential NxN matrix multiplier.
package mult_mat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  // Accumulator width: an N-term sum of 2W-bit products needs clog2(N) guard bits.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  function automatic int elem_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

  function automatic int elem_lsb(input int i, input int j, input int n, input int w);
    return elem_idx(i, j, n) * w;
  endfunction

endpackage

// File: rtl/mult_mat_reduce.sv
// Reduces a full-width dot-product sum to a W-bit element, either wrapped or saturated.
module mult_mat_reduce #(
  parameter int W   = 3,
  parameter int AW  = 7,
  parameter int SAT = 0
) (
  input  logic [AW-1:0] sum,
  output logic [W-1:0]  elem,
  output logic          ovf
);

  localparam logic [AW-1:0] MAX = {{(AW-W){1'b0}}, {W{1'b1}}};

  assign ovf  = (sum > MAX);
  assign elem = (SAT != 0 && ovf) ? {W{1'b1}} : sum[W-1:0];

endmodule

// File: rtl/mult_mat_seq.sv
// Sequential NxN unsigned matrix multiplier: one multiply-accumulate per enabled cycle,
// result published atomically when the last element is reduced.
module mult_mat_seq
  import mult_mat_pkg::*;
#(
  parameter int N   = 2,
  parameter int W   = 3,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [N*N*W-1:0] matriz_A,
  input  logic [N*N*W-1:0] matriz_B,
  output logic [N*N*W-1:0] matriz_resultado,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int AW = acc_width(W, N);
  localparam int CW = $clog2(N);
  localparam int MW = N * N * W;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state;
  logic [CW-1:0]   i, j, k;
  logic [MW-1:0]   a_reg, b_reg, res_buf, res_next;
  logic [AW-1:0]   acc, sum;
  logic [W-1:0]    a_el, b_el, elem;
  logic [2*W-1:0]  product;
  logic            elem_ovf;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    a_el     = a_reg[elem_lsb(int'(i), int'(k), N, W) +: W];
    b_el     = b_reg[elem_lsb(int'(k), int'(j), N, W) +: W];
    product  = (2*W)'(a_el) * (2*W)'(b_el);
    sum      = acc + AW'(product);
    res_next = res_buf;
    res_next[elem_lsb(int'(i), int'(j), N, W) +: W] = elem;
  end

  mult_mat_reduce #(
    .W   (W),
    .AW  (AW),
    .SAT (SAT)
  ) u_reduce (
    .sum  (sum),
    .elem (elem),
    .ovf  (elem_ovf)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      i                <= '0;
      j                <= '0;
      k                <= '0;
      acc              <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      res_buf          <= '0;
      matriz_resultado <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      overflow         <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg    <= matriz_A;
            b_reg    <= matriz_B;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (k == LAST) begin
            // Element complete: fold in the last product and step row-major.
            res_buf  <= res_next;
            acc      <= '0;
            k        <= '0;
            overflow <= overflow | elem_ovf;
            if (j == LAST) begin
              j <= '0;
              if (i == LAST) begin
                i                <= '0;
                matriz_resultado <= res_next;
                done             <= 1'b1;
                state            <= FIN;
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            acc <= sum;
            k   <= k + 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
